// File: rtl/wb_arbiter.sv
// wb_arbiter: multi-lane writeback arbiter with exception reporting and retire counter
//   clock/reset          : clock, asynchronous active-high reset
//   ch_*                 : per-lane valid/ready handshake, RF payload, PC and exception info
//   xcpt_ack             : handler acknowledge, releases the exception hold
//   req_to_RF_*          : registered RF write port (1-cycle latency)
//   xcpt_valid/type, rmPC/rmAddr : registered exception report, held until acked
//   retired_cnt          : clean retirements, wraps modulo 2^CNT_W
module wb_arbiter #(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int PC_W    = 32,
    parameter int XADDR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic [NUM_CH-1:0]         ch_write_rf,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_dest,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic [NUM_CH*PC_W-1:0]    ch_pc,
    input  logic [NUM_CH-1:0]         ch_xcpt_fetch,
    input  logic [NUM_CH-1:0]         ch_xcpt_decode,
    input  logic [NUM_CH-1:0]         ch_xcpt_cache,
    input  logic [NUM_CH*XADDR_W-1:0] ch_xcpt_addr,
    input  logic                      xcpt_ack,
    output logic                      req_to_RF_writeEn,
    output logic [ADDR_W-1:0]         req_to_RF_dest,
    output logic [DATA_W-1:0]         req_to_RF_data,
    output logic                      xcpt_valid,
    output logic [1:0]                xcpt_type,
    output logic [PC_W-1:0]           rmPC,
    output logic [XADDR_W-1:0]        rmAddr,
    output logic [CNT_W-1:0]          retired_cnt
);
    localparam int RW = $clog2(NUM_CH);
    localparam logic [0:0] RUN       = 1'b0;
    localparam logic [0:0] XCPT_HOLD = 1'b1;

    logic [0:0]         st_q, st_d;
    logic [RW-1:0]      rr_q, rr_d, gi;
    logic               we_q, we_d, xv_q, xv_d;
    logic [1:0]         xt_q, xt_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [XADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  x;
    logic               run, xfer, ok, xg, ack;

    assign x = ch_valid & (ch_xcpt_fetch | ch_xcpt_decode | ch_xcpt_cache);

    // Descending scans leave the closest match in gi: the lowest excepting
    // lane when any exception is present, else the first valid lane from rr_q.
    always_comb begin
        gi = '0;
        for (int k = NUM_CH-1; k >= 0; k--)
            if (ch_valid[(int'(rr_q) + k) % NUM_CH]) gi = RW'((int'(rr_q) + k) % NUM_CH);
        if (|x)
            for (int i = NUM_CH-1; i >= 0; i--)
                if (x[i]) gi = RW'(i);
    end

    assign run      = st_q == RUN;
    assign xfer     = run & (|ch_valid);
    assign ok       = xfer & ~(|x);
    assign xg       = xfer & (|x);
    assign ack      = (st_q == XCPT_HOLD) & xcpt_ack;
    assign ch_ready = xfer ? NUM_CH'(1) << gi : '0;

    always_comb begin
        we_d   = ok & ch_write_rf[gi];
        dest_d = ok ? ch_dest[gi*ADDR_W +: ADDR_W] : dest_q;
        data_d = ok ? ch_data[gi*DATA_W +: DATA_W] : data_q;
        cnt_d  = cnt_q + CNT_W'(ok);
        rr_d   = ok ? (gi == RW'(NUM_CH-1) ? '0 : gi + 1'b1) : rr_q;
        st_d   = xg ? XCPT_HOLD : ack ? RUN : st_q;
        xv_d   = xg ? 1'b1 : ack ? 1'b0 : xv_q;
        xt_d   = xg ? (ch_xcpt_fetch[gi] ? 2'd1 : ch_xcpt_decode[gi] ? 2'd2 : 2'd3) : ack ? 2'd0 : xt_q;
        pc_d   = xg ? ch_pc[gi*PC_W +: PC_W] : pc_q;
        addr_d = xg ? ch_xcpt_addr[gi*XADDR_W +: XADDR_W] : addr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q   <= RUN;
            rr_q   <= '0;
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            xv_q   <= 1'b0;
            xt_q   <= 2'd0;
            pc_q   <= '0;
            addr_q <= '0;
        end else begin
            st_q   <= st_d;
            rr_q   <= rr_d;
            we_q   <= we_d;
            dest_q <= dest_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            xv_q   <= xv_d;
            xt_q   <= xt_d;
            pc_q   <= pc_d;
            addr_q <= addr_d;
        end
    end

    assign req_to_RF_writeEn = we_q;
    assign req_to_RF_dest    = dest_q;
    assign req_to_RF_data    = data_q;
    assign xcpt_valid        = xv_q;
    assign xcpt_type         = xt_q;
    assign rmPC              = pc_q;
    assign rmAddr            = addr_q;
    assign retired_cnt       = cnt_q;
endmodule
